// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the multi-channel PWM generator
// Contents: counter direction enum, counting mode enum, default parameter
// values, and the reset value used for the active/shadow period registers.
package pwm_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_RESOLUTION_BITS = 8;
    localparam int DEF_PRESCALER_BITS  = 10;

    // Period registers come out of reset at full scale; users slice the
    // low RESOLUTION_BITS of this constant.
    localparam logic [31:0] PERIOD_RESET_ALL = '1;

endpackage

// File: rtl/pwm_multichannel_if.sv
// rtl/pwm_multichannel_if.sv - configuration/update bus between register file and PWM block
// Signals:
//   period_in    requested top count, captured with duty_valid
//   duty_in      packed per-channel duties, channel i at [i*RESOLUTION_BITS +: RESOLUTION_BITS]
//   duty_valid   single-cycle strobe writing period_in/duty_in into the shadow set
//   center_mode  1 = up/down counting, taken when the shadow set commits
//   update_ack   one-clk pulse from the PWM block when the shadow set became active
// Modports: master = register file side, slave = PWM block side.
interface pwm_multichannel_if
    import pwm_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int RESOLUTION_BITS = DEF_RESOLUTION_BITS
);
    logic [RESOLUTION_BITS-1:0]          period_in;
    logic [CHANNELS*RESOLUTION_BITS-1:0] duty_in;
    logic                                duty_valid;
    logic                                center_mode;
    logic                                update_ack;

    modport master (
        output period_in,
        output duty_in,
        output duty_valid,
        output center_mode,
        input  update_ack
    );

    modport slave (
        input  period_in,
        input  duty_in,
        input  duty_valid,
        input  center_mode,
        output update_ack
    );
endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow duty, active duty, registered compare
// Ports:
//   clk, rst     system clock, synchronous active-low reset
//   enable       run/stop; low forces the output low
//   load         duty write strobe, captures duty_in into the shadow register
//   commit       shared strobe from the top moving the duty into the active register
//   duty_in      this channel's duty from the configuration bus
//   value        shared counter value
//   pwm          registered output, high while value < active duty
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int RESOLUTION_BITS = DEF_RESOLUTION_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       load,
    input  logic                       commit,
    input  logic [RESOLUTION_BITS-1:0] duty_in,
    input  logic [RESOLUTION_BITS-1:0] value,
    output logic                       pwm
);

    logic [RESOLUTION_BITS-1:0] shadow_duty_q, shadow_duty_d;
    logic [RESOLUTION_BITS-1:0] active_duty_q, active_duty_d;
    logic                       pwm_q, pwm_d;

    always_comb begin
        shadow_duty_d = shadow_duty_q;
        active_duty_d = active_duty_q;
        if (load) begin
            shadow_duty_d = duty_in;
        end
        // A write landing on the commit cycle bypasses the shadow register.
        if (commit) begin
            active_duty_d = load ? duty_in : shadow_duty_q;
        end
        // Compare uses the duty active during this period, so a commit on
        // the boundary only affects the first value of the next period.
        pwm_d = enable & (value < active_duty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_duty_q <= '0;
            active_duty_q <= '0;
            pwm_q         <= 1'b0;
        end else begin
            shadow_duty_q <= shadow_duty_d;
            active_duty_q <= active_duty_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - prescaler, shared period counter and CHANNELS duty comparators
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   enable        run/stop; low holds prescaler and counter at 0 and outputs low
//   prescale_div  counter advances every prescale_div+1 clocks (sampled live)
//   cfg           slave side of pwm_multichannel_if (period/duty writes, update_ack)
//   ena           registered prescaler tick
//   value         current counter value
//   period_end    registered pulse on the tick that ends a period
//   pwm_out       registered per-channel PWM outputs
// Build option: PWM_CENTER_ALIGNED_EN adds up/down counting selected by
// cfg.center_mode; without it the block is edge-aligned only.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int RESOLUTION_BITS = DEF_RESOLUTION_BITS,
    parameter int PRESCALER_BITS  = DEF_PRESCALER_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [PRESCALER_BITS-1:0]  prescale_div,
    pwm_multichannel_if.slave          cfg,
    output logic                       ena,
    output logic [RESOLUTION_BITS-1:0] value,
    output logic                       period_end,
    output logic [CHANNELS-1:0]        pwm_out
);

    localparam logic [RESOLUTION_BITS-1:0] PERIOD_RST = PERIOD_RESET_ALL[RESOLUTION_BITS-1:0];
    localparam logic [RESOLUTION_BITS-1:0] VAL_ONE    = RESOLUTION_BITS'(1);

    logic [PRESCALER_BITS-1:0]  presc_q, presc_d;
    logic [RESOLUTION_BITS-1:0] value_q, value_d;
    logic                       ena_q, ena_d;
    logic                       period_end_q, period_end_d;
    logic                       update_ack_q, update_ack_d;
    logic                       pending_q, pending_d;
    logic [RESOLUTION_BITS-1:0] shadow_period_q, shadow_period_d;
    logic [RESOLUTION_BITS-1:0] active_period_q, active_period_d;

    logic tick;
    logic boundary;
    logic commit;

`ifdef PWM_CENTER_ALIGNED_EN
    mode_e mode_q, mode_d;
    dir_e  dir_q, dir_d;
`else
    logic unused_center_mode;
    assign unused_center_mode = cfg.center_mode;
`endif

    // Prescaler. A divider shrunk below the running count restarts the
    // count without producing a tick.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (!enable) begin
            presc_d = '0;
        end else if (presc_q == prescale_div) begin
            presc_d = '0;
            tick    = 1'b1;
        end else if (presc_q > prescale_div) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESCALER_BITS'(1);
        end
    end

    // Period counter. The >= tests keep the counter bounded even if the
    // active period were ever below the running value.
    always_comb begin
        value_d  = value_q;
        boundary = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        dir_d    = dir_q;
`endif
        if (!enable) begin
            value_d = '0;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_d   = DIR_UP;
`endif
        end else if (tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
            if (mode_q == MODE_CENTER) begin
                if (dir_q == DIR_UP) begin
                    if (value_q >= active_period_q) begin
                        if (active_period_q == '0) begin
                            value_d  = '0;
                            boundary = 1'b1;
                        end else begin
                            // Turn around without repeating the top value.
                            value_d = active_period_q - VAL_ONE;
                            dir_d   = DIR_DOWN;
                        end
                    end else begin
                        value_d = value_q + VAL_ONE;
                    end
                end else begin
                    if (value_q == '0) begin
                        // Bottom while counting down closes the period.
                        value_d  = (active_period_q == '0) ? '0 : VAL_ONE;
                        dir_d    = DIR_UP;
                        boundary = 1'b1;
                    end else begin
                        value_d = value_q - VAL_ONE;
                    end
                end
            end else
`endif
            begin
                if (value_q >= active_period_q) begin
                    value_d  = '0;
                    boundary = 1'b1;
                end else begin
                    value_d = value_q + VAL_ONE;
                end
            end
        end
    end

    // Shadow/active period and commit control. While stopped there is no
    // period to protect, so any pending or incoming write commits at once.
    always_comb begin
        commit = enable ? (boundary & (pending_q | cfg.duty_valid))
                        : (pending_q | cfg.duty_valid);

        shadow_period_d = cfg.duty_valid ? cfg.period_in : shadow_period_q;
        active_period_d = active_period_q;
        if (commit) begin
            active_period_d = cfg.duty_valid ? cfg.period_in : shadow_period_q;
        end

        pending_d = pending_q;
        if (cfg.duty_valid) begin
            pending_d = 1'b1;
        end
        if (commit) begin
            pending_d = 1'b0;
        end

`ifdef PWM_CENTER_ALIGNED_EN
        mode_d = mode_q;
        if (commit) begin
            mode_d = cfg.center_mode ? MODE_CENTER : MODE_EDGE;
        end
`endif

        ena_d        = tick;
        period_end_d = boundary;
        update_ack_d = commit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q         <= '0;
            value_q         <= '0;
            ena_q           <= 1'b0;
            period_end_q    <= 1'b0;
            update_ack_q    <= 1'b0;
            pending_q       <= 1'b0;
            shadow_period_q <= PERIOD_RST;
            active_period_q <= PERIOD_RST;
`ifdef PWM_CENTER_ALIGNED_EN
            mode_q          <= MODE_EDGE;
            dir_q           <= DIR_UP;
`endif
        end else begin
            presc_q         <= presc_d;
            value_q         <= value_d;
            ena_q           <= ena_d;
            period_end_q    <= period_end_d;
            update_ack_q    <= update_ack_d;
            pending_q       <= pending_d;
            shadow_period_q <= shadow_period_d;
            active_period_q <= active_period_d;
`ifdef PWM_CENTER_ALIGNED_EN
            mode_q          <= mode_d;
            dir_q           <= dir_d;
`endif
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .RESOLUTION_BITS(RESOLUTION_BITS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .load    (cfg.duty_valid),
            .commit  (commit),
            .duty_in (cfg.duty_in[i*RESOLUTION_BITS +: RESOLUTION_BITS]),
            .value   (value_q),
            .pwm     (pwm_out[i])
        );
    end

    assign ena            = ena_q;
    assign value          = value_q;
    assign period_end     = period_end_q;
    assign cfg.update_ack = update_ack_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb/tb_pwm_multichannel.sv - scoreboard bench for pwm_multichannel
module tb_pwm_multichannel;

    localparam int CH = 4;
    localparam int RB = 8;
    localparam int PB = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [PB-1:0] prescale_div;
    logic          ena;
    logic [RB-1:0] value;
    logic          period_end;
    logic [CH-1:0] pwm_out;

    pwm_multichannel_if #(.CHANNELS(CH), .RESOLUTION_BITS(RB)) cfg ();

    pwm_multichannel #(
        .CHANNELS(CH),
        .RESOLUTION_BITS(RB),
        .PRESCALER_BITS(PB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .prescale_div (prescale_div),
        .cfg          (cfg),
        .ena          (ena),
        .value        (value),
        .period_end   (period_end),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ena;
        logic [RB-1:0] value;
        logic          pe;
        logic          ack;
        logic [CH-1:0] pwm;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Driven configuration values.
    int d_period;
    int d_duty[CH];
    bit d_dv;
    bit d_cm;

    // Reference model: prescale phase, position within the period, and the
    // active/shadow settings.  In center mode a period of 2P ticks is laid
    // out as position 0..2P-1 folded into value = min(pos, 2P-pos).
    int m_pc, m_pos, m_per, m_sh_per;
    bit m_pend, m_fresh, m_center;
    int m_duty[CH];
    int m_sh_duty[CH];

    function automatic int cur_value();
        if (m_center) return (m_pos <= m_per) ? m_pos : 2 * m_per - m_pos;
        return m_pos;
    endfunction

    task automatic model_step();
        exp_t e;
        int   cv;
        bit   tick, bnd, commit;
        e = '0;
        if (!rst) begin
            m_pc = 0; m_pos = 0; m_per = (1 << RB) - 1; m_sh_per = (1 << RB) - 1;
            m_pend = 0; m_fresh = 1; m_center = 0;
            for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_sh_duty[i] = 0; end
            sb_q.push_back(e);
            return;
        end
        cv = cur_value();
        for (int i = 0; i < CH; i++) e.pwm[i] = enable && (cv < m_duty[i]);
        tick = 0; bnd = 0;
        if (!enable) begin
            m_pc = 0; m_pos = 0; m_fresh = 1;
        end else if (m_pc == int'(prescale_div)) begin
            m_pc = 0; tick = 1;
        end else if (m_pc > int'(prescale_div)) begin
            m_pc = 0;
        end else begin
            m_pc++;
        end
        if (tick) begin
            if (!m_center) begin
                if (m_pos >= m_per) begin m_pos = 0; bnd = 1; m_fresh = 1; end
                else m_pos++;
            end else if (m_per == 0) begin
                m_pos = 0; bnd = 1;
            end else begin
                if (m_pos == 0 && !m_fresh) bnd = 1;
                m_pos = (m_pos + 1) % (2 * m_per);
                m_fresh = 0;
            end
        end
        commit = enable ? (bnd && (m_pend || d_dv)) : (m_pend || d_dv);
        if (commit) begin
            m_per = d_dv ? d_period : m_sh_per;
            for (int i = 0; i < CH; i++) m_duty[i] = d_dv ? d_duty[i] : m_sh_duty[i];
`ifdef PWM_CENTER_ALIGNED_EN
            m_center = d_cm;
`endif
        end
        if (d_dv) begin
            m_sh_per = d_period;
            for (int i = 0; i < CH; i++) m_sh_duty[i] = d_duty[i];
            m_pend = 1;
        end
        if (commit) m_pend = 0;
        e.ena   = tick;
        e.pe    = bnd;
        e.ack   = commit;
        e.value = RB'(cur_value());
        sb_q.push_back(e);
    endtask

    task automatic apply();
        cfg.period_in   = RB'(d_period);
        cfg.duty_valid  = d_dv;
        cfg.center_mode = d_cm;
        for (int i = 0; i < CH; i++) cfg.duty_in[i*RB +: RB] = RB'(d_duty[i]);
        model_step();
        @(posedge clk);
        #1;
        d_dv = 0;
        cfg.duty_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) apply();
    endtask

    task automatic write(input int per, input int a, input int b, input int c, input int d);
        d_period = per;
        d_duty[0] = a; d_duty[1] = b; d_duty[2] = c; d_duty[3] = d;
        d_dv = 1;
        apply();
    endtask

    task automatic wait_val(input int target, input int limit);
        int n = 0;
        while (cur_value() != target && n < limit) begin apply(); n++; end
        vectors++;
        if (cur_value() != target) begin
            $display("FAIL wait_val: value %0d not reached within %0d cycles (model at %0d)",
                     target, limit, cur_value());
            miscompares++;
        end
    endtask

    // Monitor: the front entry describes the outputs after the most recent edge.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (sb_q.size() >= 2) begin
                e = sb_q.pop_front();
                vectors++;
                bad = 0;
                if (ena !== e.ena) begin
                    $display("FAIL ena @%0t: got %b expected %b", $time, ena, e.ena); bad = 1;
                end
                if (value !== e.value) begin
                    $display("FAIL value @%0t: got %0d expected %0d", $time, value, e.value); bad = 1;
                end
                if (period_end !== e.pe) begin
                    $display("FAIL period_end @%0t: got %b expected %b", $time, period_end, e.pe); bad = 1;
                end
                if (cfg.update_ack !== e.ack) begin
                    $display("FAIL update_ack @%0t: got %b expected %b", $time, cfg.update_ack, e.ack); bad = 1;
                end
                if (pwm_out !== e.pwm) begin
                    $display("FAIL pwm_out @%0t: got %b expected %b", $time, pwm_out, e.pwm); bad = 1;
                end
                if (bad) miscompares++;
            end
        end
    end

    initial begin
        rst = 1'b0; enable = 1'b0; prescale_div = '0;
        d_period = 0; d_dv = 0; d_cm = 0;
        for (int i = 0; i < CH; i++) d_duty[i] = 0;
        cfg.period_in = '0; cfg.duty_in = '0; cfg.duty_valid = 1'b0; cfg.center_mode = 1'b0;

        run(3);                       // reset state
        rst = 1'b1;
        run(2);                       // stopped, nothing moves
        write(9, 0, 3, 9, 10);        // commits at once while stopped
        enable = 1'b1;
        run(40);                      // duties 0/3/9/10 of 10, period_end every 10

        prescale_div = 4;
        write(3, 1, 2, 3, 4);
        run(70);                      // ena every 5, period_end every 20

        prescale_div = 0;
        write(9, 3, 3, 9, 10);
        run(25);
        wait_val(5, 40);
        write(9, 7, 3, 9, 10);        // mid-period duty change on ch0
        run(25);

        wait_val(9, 40);
        write(9, 1, 2, 3, 4);         // write on the boundary cycle
        run(15);

`ifdef PWM_CENTER_ALIGNED_EN
        d_cm = 1;
        write(4, 2, 2, 2, 2);
        run(40);
        d_cm = 0;
        write(9, 3, 3, 9, 10);
        run(20);
`endif

        wait_val(4, 40);
        write(9, 5, 5, 5, 5);         // pending write, then reset
        rst = 1'b0;
        apply();
        rst = 1'b1;
        run(270);                     // period back to 255, no ack

        for (int k = 0; k < 700; k++) begin
            rst = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 49) == 0) prescale_div = PB'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
`ifdef PWM_CENTER_ALIGNED_EN
                d_period = $urandom_range(1, 12);
                d_cm     = $urandom_range(0, 1);
`else
                d_period = $urandom_range(0, 12);
                d_cm     = $urandom_range(0, 1);
`endif
                for (int i = 0; i < CH; i++) d_duty[i] = $urandom_range(0, 14);
                d_dv = 1;
            end
            apply();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Multi-channel PWM generator for the PWM subsystem: one runtime-programmable prescaler, one shared period counter, and CHANNELS independent duty comparators with registered outputs. Duty and period writes are double-buffered and committed only at a period boundary, so outputs never glitch mid-period. It is the parametrised successor of the single-channel prescaler/counter/comparator chain and sits directly between the control register file and the output pads.

## Interface
- CHANNELS, 4: number of PWM outputs sharing one counter
- RESOLUTION_BITS, 8: width of counter, period and each duty value
- PRESCALER_BITS, 10: width of prescaler counter and divider input
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- enable  in  1  run/stop; low holds prescaler and counter at 0
- prescale_div  in  PRESCALER_BITS  tick every prescale_div+1 clk cycles; sampled live
- period_in  in  RESOLUTION_BITS  requested top count; captured with duty_valid
- duty_in  in  CHANNELS*RESOLUTION_BITS  channel i duty at bits [i*RB +: RB]
- duty_valid  in  1  single-cycle strobe capturing period_in/duty_in into shadow
- center_mode  in  1  1 = up/down counting (only with macro); sampled at period boundary
- ena  out  1  prescaler tick, one clk wide
- value  out  RESOLUTION_BITS  current counter value
- period_end  out  1  one-clk pulse on the tick that ends a period
- update_ack  out  1  one-clk pulse when shadow commits to active
- pwm_out  out  CHANNELS  registered PWM outputs

## Operation
- Reset (rst=0 on a clk edge): prescaler=0, value=0, direction=up, ena=0, period_end=0, update_ack=0, pwm_out=0, pending flag=0, active/shadow duties=0, active/shadow period=all-ones, active mode=edge.
- Prescaler: counts 0..prescale_div; ena=1 on the cycle count==prescale_div, count then returns to 0. prescale_div=0 -> ena every cycle. Divider shrunk below current count -> count wraps to 0 next cycle, no ena that cycle.
- Edge mode: on ena, value increments; at value==active_period it wraps to 0 and period_end=1 on that ena cycle.
- Center mode: on ena, counts up to active_period, then down to 0; direction flips at each end, no value repeats at turnaround; period_end=1 on the ena cycle where value==0 while counting down. active_period=0 -> value stays 0, period_end every ena.
- Compare: pwm_out[i] next = enable & (value < active_duty[i]). duty=0 -> constant low; duty>active_period -> constant high. Unsigned compare, RESOLUTION_BITS wide, no overflow.
- Shadow: duty_valid writes shadow period/duties, sets pending. On period_end with pending: active <= shadow, center_mode sampled, pending cleared, update_ack=1 next cycle.
- Simultaneous duty_valid and period_end: the incoming values commit directly at that boundary; a single update_ack follows.
- Repeated duty_valid before boundary: last write wins, one ack.
- enable=0: prescaler/value forced 0, direction up, pwm_out=0, no ena/period_end; shadow is transparent (any pending commits next cycle with update_ack). Restart after enable=1 begins a fresh period at value 0.
- Reset mid-period or mid-update: pending write discarded, no ack.

## Timing
- ena, period_end, update_ack, pwm_out all registered.
- pwm_out lags value by one clk.
- Shadow -> active commit: the clk edge of the period_end cycle; new duties reflected on pwm_out two clk after that tick.
- Edge period = (active_period+1)*(prescale_div+1) clk; center period = 2*active_period*(prescale_div+1) clk (active_period>=1).

## Configuration
- PWM_CENTER_ALIGNED_EN defined: center_mode honoured, up/down counter and direction register built.
- Undefined: center_mode ignored (port kept, unloaded), edge mode only, no direction register.

## Structure
- Package pwm_pkg: direction enum (DIR_UP, DIR_DOWN), mode enum (MODE_EDGE, MODE_CENTER), default parameter constants, reset value of period (all-ones).
- Sub-module pwm_channel: one per channel via generate; holds shadow duty, active duty and registered compare; shared commit strobe from top.

## Test plan
- RB=8, prescale_div=0, period=9, duties {0,3,9,10}: pwm_out low always / high 3 of 10 / 9 of 10 / always high; period_end every 10 clk.
- prescale_div=4, period=3: ena every 5 clk, period_end every 20 clk, value steps only on ena.
- duty_valid of ch0 3->7 at value=5: pwm_out[0] unchanged for rest of period, update_ack after wrap, 7-high next period.
- duty_valid on same cycle as period_end: new duty used for the immediately following period, exactly one update_ack.
- With macro, center_mode=1, period=4, duty=2: value 0,1,2,3,4,3,2,1,0,...; pwm_out high while value<2; period_end at value 0 going down.
- rst=0 mid-period with pending write: all outputs 0 next clk, period reverts to 255, no update_ack after release.
